// File: rtl/updown_counter_pkg.sv
// Shared types and elaboration helpers for the modulo-N up/down counter.
package updown_counter_pkg;

  // Operation chosen for each clock edge by the priority decode.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } cnt_op_t;

  localparam int MIN_MODULUS = 2;

  // The compare width has one spare bit, so MODULUS == 2**WIDTH is representable.
  function automatic int cmp_width(input int width);
    return width + 1;
  endfunction

  // Legal modulus range: MIN_MODULUS .. 2**WIDTH.
  function automatic bit modulus_ok(input int width, input int modulus);
    longint max_mod;
    max_mod = longint'(64'd1 << width);
    return (modulus >= MIN_MODULUS) && (longint'(modulus) <= max_mod);
  endfunction

endpackage

// File: rtl/updown_counter_dff_reg.sv
// dff_reg: WIDTH-bit register with asynchronous active-high reset to RESET_VALUE.
module dff_reg #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Capture d_i on every rising edge; reset forces RESET_VALUE immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= RESET_VALUE;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo-MODULUS up/down counter with clear, load, enable,
// wrap/saturate boundary handling and a registered boundary pulse (limit).
// Optional macro UDCNT_STICKY_OVF_EN adds the ovf_sticky output.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
`ifdef UDCNT_STICKY_OVF_EN
  output logic             ovf_sticky,
`endif
  output logic             limit
);

  localparam int               CW      = cmp_width(WIDTH);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [CW-1:0]    MOD_CW  = CW'(MODULUS);

  // Reject illegal parameter sets at elaboration time.
  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("updown_counter_mod: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  if ((RESET_VALUE < 0) || (RESET_VALUE >= MODULUS)) begin : g_bad_reset_value
    $error("updown_counter_mod: RESET_VALUE %0d must be below MODULUS", RESET_VALUE);
  end

  cnt_op_t          op;
  logic [WIDTH-1:0] count_q, count_d;
  logic             limit_q, limit_d;
  logic [WIDTH-1:0] load_clamped;

  // Out-of-range load values are clamped to the top of the count range.
  assign load_clamped = ({1'b0, load_value} < MOD_CW) ? load_value : MAX_VAL;

  // Priority decode: clear > load > en > hold.
  always_comb begin
    op = OP_HOLD;
    if (clear) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_INC : OP_DEC;
    end
  end

  // Next count and boundary pulse for the decoded operation.
  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    unique case (op)
      OP_CLEAR: count_d = RST_VAL;
      OP_LOAD:  count_d = load_clamped;
      OP_INC: begin
        if ({1'b0, count_q} < {1'b0, MAX_VAL}) begin
          count_d = count_q + 1'b1;
        end else begin
          limit_d = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end
      end
      OP_DEC: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          limit_d = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_VAL;
        end
      end
      default: count_d = count_q;
    endcase
  end

  dff_reg #(.WIDTH(WIDTH), .RESET_VALUE(RST_VAL)) u_count_reg (
    .clk_i(clk), .rst_i(reset), .d_i(count_d), .q_o(count_q)
  );

  dff_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) u_limit_reg (
    .clk_i(clk), .rst_i(reset), .d_i(limit_d), .q_o(limit_q)
  );

`ifdef UDCNT_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky flag: set alongside limit, cleared only by clear or reset.
  always_comb begin
    ovf_d = clear ? 1'b0 : (ovf_q | limit_d);
  end

  dff_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) u_ovf_reg (
    .clk_i(clk), .rst_i(reset), .d_i(ovf_d), .q_o(ovf_q)
  );

  assign ovf_sticky = ovf_q;
`endif

  assign count  = count_q;
  assign limit  = limit_q;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: three instances (mod-10 wrap, mod-10 saturate,
// mod-16 wrap) share one stimulus stream and are checked each cycle against a
// behavioural model, plus directed literal expectations.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       en = 1'b0;
  logic       up = 1'b1;

  logic [3:0] dut_cnt [3];
  logic       dut_lim [3];
  logic       dut_max [3];
  logic       dut_min [3];
  logic       dut_ovf [3];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  localparam int MODS [3] = '{10, 10, 16};
  localparam int SATS [3] = '{0, 1, 0};

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) u_wrap10 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .up(up), .count(dut_cnt[0]), .at_max(dut_max[0]), .at_min(dut_min[0]),
`ifdef UDCNT_STICKY_OVF_EN
    .ovf_sticky(dut_ovf[0]),
`endif
    .limit(dut_lim[0]));

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VALUE(0)) u_sat10 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .up(up), .count(dut_cnt[1]), .at_max(dut_max[1]), .at_min(dut_min[1]),
`ifdef UDCNT_STICKY_OVF_EN
    .ovf_sticky(dut_ovf[1]),
`endif
    .limit(dut_lim[1]));

  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VALUE(0)) u_wrap16 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .up(up), .count(dut_cnt[2]), .at_max(dut_max[2]), .at_min(dut_min[2]),
`ifdef UDCNT_STICKY_OVF_EN
    .ovf_sticky(dut_ovf[2]),
`endif
    .limit(dut_lim[2]));

`ifndef UDCNT_STICKY_OVF_EN
  initial for (int i = 0; i < 3; i++) dut_ovf[i] = 1'b0;
`endif

  // Behavioural model state, one entry per instance.
  int m_cnt [3];
  int m_lim [3];
  int m_ovf [3];

  function automatic void model_step(input int c, input int o, input int md, input int sat,
                                     output int nc, output int nl, output int no);
    nc = c;
    nl = 0;
    if (clear) begin
      nc = 0;
    end else if (load) begin
      nc = (int'(load_value) < md) ? int'(load_value) : md - 1;
    end else if (en && up) begin
      if (c + 1 < md) nc = c + 1;
      else begin nl = 1; nc = sat ? c : 0; end
    end else if (en && !up) begin
      if (c > 0) nc = c - 1;
      else begin nl = 1; nc = sat ? 0 : md - 1; end
    end
    no = clear ? 0 : ((o != 0 || nl != 0) ? 1 : 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_lim[i] = 0; m_ovf[i] = 0;
      end else begin
        int nc, nl, no;
        model_step(m_cnt[i], m_ovf[i], MODS[i], SATS[i], nc, nl, no);
        m_cnt[i] = nc; m_lim[i] = nl; m_ovf[i] = no;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model count[%0d]", i), 32'(dut_cnt[i]), 32'(m_cnt[i]));
        check($sformatf("model limit[%0d]", i), 32'(dut_lim[i]), 32'(m_lim[i]));
        check($sformatf("model at_max[%0d]", i), 32'(dut_max[i]), 32'(m_cnt[i] == MODS[i] - 1));
        check($sformatf("model at_min[%0d]", i), 32'(dut_min[i]), 32'(m_cnt[i] == 0));
`ifdef UDCNT_STICKY_OVF_EN
        check($sformatf("model ovf[%0d]", i), 32'(dut_ovf[i]), 32'(m_ovf[i]));
`endif
      end
    end
  end

  int exp_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    // Reset state.
    reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("reset count", 32'(dut_cnt[0]), 32'd0);
    check("reset limit", 32'(dut_lim[0]), 32'd0);
    check("reset at_min", 32'(dut_min[0]), 32'd1);
    reset = 1'b0;
    $display("txn reset released");

    // Count up 12 cycles through the wrap.
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("up count", 32'(dut_cnt[0]), 32'(exp_seq[k]));
      check("up limit", 32'(dut_lim[0]), 32'(k == 9));
      check("up at_max", 32'(dut_max[0]), 32'(exp_seq[k] == 9));
      $display("txn up step %0d count=%0d limit=%0d", k, dut_cnt[0], dut_lim[0]);
    end

    // Saturating instance: load 1, then count down into the floor.
    en = 1'b0; load = 1'b1; load_value = 4'd1;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sat count", 32'(dut_cnt[1]), 32'd0);
      check("sat limit", 32'(dut_lim[1]), 32'(k != 0));
      check("sat at_min", 32'(dut_min[1]), 32'd1);
      $display("txn sat down %0d count=%0d limit=%0d", k, dut_cnt[1], dut_lim[1]);
    end

    // Clamped load, then load together with en.
    en = 1'b0; load = 1'b1; load_value = 4'd13;
    @(negedge clk);
    check("clamp load", 32'(dut_cnt[0]), 32'd9);
    check("load 13 mod16", 32'(dut_cnt[2]), 32'd13);
    load_value = 4'd4; en = 1'b1; up = 1'b1;
    @(negedge clk);
    check("load beats en", 32'(dut_cnt[0]), 32'd4);
    $display("txn load/en count=%0d", dut_cnt[0]);

    // Clear beats load, then asynchronous reset mid-cycle.
    en = 1'b0; load_value = 4'd7;
    @(negedge clk);
    check("load 7", 32'(dut_cnt[0]), 32'd7);
    clear = 1'b1; load_value = 4'd5;
    @(negedge clk);
    check("clear beats load", 32'(dut_cnt[0]), 32'd0);
    clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (3) @(negedge clk);
    check("pre-reset count", 32'(dut_cnt[0]), 32'd3);
    #2 reset = 1'b1;
    #1 check("async reset count", 32'(dut_cnt[0]), 32'd0);
    check("async reset mod16", 32'(dut_cnt[2]), 32'd0);
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    $display("txn async reset done");

    // Full-range modulus wraps both directions.
    load = 1'b1; load_value = 4'd15;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1;
    @(negedge clk);
    check("mod16 wrap up count", 32'(dut_cnt[2]), 32'd0);
    check("mod16 wrap up limit", 32'(dut_lim[2]), 32'd1);
    check("mod10 wrap up count", 32'(dut_cnt[0]), 32'd0);
    up = 1'b0;
    @(negedge clk);
    check("mod16 wrap down count", 32'(dut_cnt[2]), 32'd15);
    check("mod16 wrap down limit", 32'(dut_lim[2]), 32'd1);
    check("mod10 wrap down count", 32'(dut_cnt[0]), 32'd9);
    en = 1'b0;
    $display("txn mod16 wraps count=%0d", dut_cnt[2]);

    // Sticky overflow survives load, drops on clear.
    load = 1'b1; load_value = 4'd3;
    @(negedge clk);
    check("load 3", 32'(dut_cnt[0]), 32'd3);
`ifdef UDCNT_STICKY_OVF_EN
    check("ovf after load", 32'(dut_ovf[0]), 32'd1);
`endif
    load = 1'b0; clear = 1'b1;
    @(negedge clk);
    check("clear count", 32'(dut_cnt[0]), 32'd0);
`ifdef UDCNT_STICKY_OVF_EN
    check("ovf after clear", 32'(dut_ovf[0]), 32'd0);
`endif
    clear = 1'b0;
    $display("txn sticky sequence done");

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      clear = ($urandom_range(0, 29) == 0);
      load = ($urandom_range(0, 9) == 0);
      load_value = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      up = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("txn rand %0d async reset", k);
      end else begin
        @(negedge clk);
        if (k % 250 == 0)
          $display("txn rand %0d count=%0d/%0d/%0d", k, dut_cnt[0], dut_cnt[1], dut_cnt[2]);
      end
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
